// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the PipelinedARMv8 hazard/sequencing controller.
package pipeline_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Load-use stall, taken-branch flush and debug freeze/single-step sequencer
// for the 5-stage pipeline; all control outputs are combinational.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic [REG_W-1:0] if_id_rn,
  input  logic [REG_W-1:0] if_id_rm,
  input  logic             if_id_uses_rm,
  input  logic             mem_branch_taken,
  output logic             advance,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pc_src,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int SC_W = 2;
  localparam logic [SC_W-1:0] STALL_INIT = SC_W'(LOAD_STALL_CYCLES - 1);

  state_e          state_q, state_d;
  logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
  logic            step_prev_q;

  logic            step_pulse;
  logic            adv;
  logic            load_use;
  state_e          eff_state;
  logic            do_branch;
  logic            do_stall;
  logic            do_normal;
  logic [SC_W-1:0] stall_cnt_dec;

  assign load_use = id_ex_mem_read && (id_ex_rd != XZR) &&
                    ((id_ex_rd == if_id_rn) ||
                     (if_id_uses_rm && (id_ex_rd == if_id_rm)));

  assign stall_cnt_dec = stall_cnt_q - SC_W'(1);

  // A single-stepped cycle out of FREEZE behaves like the state that was
  // interrupted: STALL if bubbles are still owed, otherwise RUN.
  always_comb begin
    step_pulse = step & ~step_prev_q;
    adv        = reset & ((state_q != ST_FREEZE) | step_pulse);
    eff_state  = state_q;
    if (state_q == ST_FREEZE)
      eff_state = (stall_cnt_q != '0) ? ST_STALL : ST_RUN;
    do_branch = adv & mem_branch_taken;
    do_stall  = adv & ~mem_branch_taken &
                (((eff_state == ST_RUN) & load_use) |
                 ((eff_state == ST_STALL) & (stall_cnt_q != '0)));
    do_normal = adv & ~do_branch & ~do_stall;
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    if (adv) begin
      if (do_branch) begin
        state_d     = ST_RUN;
        stall_cnt_d = '0;
      end else if (do_stall) begin
        if (eff_state == ST_RUN) begin
          stall_cnt_d = STALL_INIT;
          state_d     = (STALL_INIT != '0) ? ST_STALL : ST_RUN;
        end else begin
          stall_cnt_d = stall_cnt_dec;
          state_d     = (stall_cnt_dec != '0) ? ST_STALL : ST_RUN;
        end
      end else begin
        state_d = ST_RUN;
      end
    end
    // The run switch overrides; the owed stall count survives a freeze.
    if (!run)
      state_d = ST_FREEZE;
    else if (state_d == ST_FREEZE)
      state_d = (stall_cnt_d != '0) ? ST_STALL : ST_RUN;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      step_prev_q <= step;
    end
  end

  assign advance      = adv;
  assign pc_write     = do_branch | do_normal;
  assign if_id_write  = do_branch | do_normal;
  assign if_id_flush  = do_branch;
  assign id_ex_flush  = do_branch | do_stall;
  assign ex_mem_flush = do_branch;
  assign pc_src       = do_branch;
  assign state        = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (do_stall),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (do_branch),
    .count (flush_count)
  );

endmodule
